// File: rtl/ternary_popcount_acc_pkg.sv
// Shared widths, FSM state type and popcount truncation helper for the ternary popcount accumulator.
// Pure declarations: no latency, no flow control.
package popcount_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int pc_w(input int n);
    return $clog2(n + 1);
  endfunction

  // One extra bit over the magnitude range so +/-n*beats fits in two's complement
  function automatic int sum_w(input int n, input int beats);
    return $clog2(n * beats + 1) + 1;
  endfunction

  function automatic int trunc_pc(input int value, input int lsbs);
    return (value >> lsbs) << lsbs;
  endfunction

endpackage

// File: rtl/ternary_popcount_acc_if.sv
// Beat input and frame result channels of the ternary popcount accumulator.
// Both channels use valid/ready; the accumulator is the slave side.
interface ternary_popcount_acc_if #(
  parameter int IN_W  = 23,
  parameter int SUM_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_pos;
  logic [IN_W-1:0]         in_neg;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [SUM_W-1:0] out_sum;
  logic                    out_fire;

  modport master (
    output in_valid, in_pos, in_neg, out_ready,
    input  in_ready, out_valid, out_sum, out_fire
  );

  modport slave (
    input  in_valid, in_pos, in_neg, out_ready,
    output in_ready, out_valid, out_sum, out_fire
  );
endinterface

// File: rtl/ternary_popcount_acc_popcount_comb.sv
// Exact combinational popcount of an IN_W-bit vector.
// Zero latency, no flow control.
module popcount_comb
  import popcount_pkg::*;
#(
  parameter int IN_W = 23
) (
  input  logic [IN_W-1:0]       bits_i,
  output logic [pc_w(IN_W)-1:0] cnt_o
);
  localparam int PC_W = pc_w(IN_W);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      cnt_o = cnt_o + PC_W'(bits_i[i]);
    end
  end
endmodule

// File: rtl/ternary_popcount_acc.sv
// Accumulates signed ternary popcount deltas over BEATS beats; result one cycle after last beat, held until taken.
// in_ready drops only while a result is held and out_ready is low. Build macro: TERNARY_POPCOUNT_APPROX_EN.
module ternary_popcount_acc
  import popcount_pkg::*;
#(
  parameter int IN_W   = 23,
  parameter int BEATS  = 4,
  parameter int THRESH = 0,
  parameter int TRUNC  = 1
) (
  input logic clk,
  input logic rst_n,
  ternary_popcount_acc_if.slave bus
);
  localparam int PC_W   = pc_w(IN_W);
  localparam int SUM_W  = sum_w(IN_W, BEATS);
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef TERNARY_POPCOUNT_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif
  localparam int TRUNC_BITS = APPROX_EN ? TRUNC : 0;

  localparam logic signed [SUM_W-1:0] THRESH_S = SUM_W'(THRESH);
  localparam logic [BCNT_W-1:0]       LAST_BEAT = BCNT_W'(BEATS - 1);

  state_t                  state_q, state_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic [BCNT_W-1:0]       beat_q, beat_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [SUM_W-1:0] out_sum_q, out_sum_d;
  logic                    out_fire_q, out_fire_d;

  logic [PC_W-1:0]         pc_pos, pc_neg, pc_pos_t, pc_neg_t;
  logic signed [SUM_W-1:0] beat_delta, acc_sum;
  logic                    beat_acc, last_beat;

  popcount_comb #(.IN_W(IN_W)) u_pc_pos (.bits_i(bus.in_pos), .cnt_o(pc_pos));
  popcount_comb #(.IN_W(IN_W)) u_pc_neg (.bits_i(bus.in_neg), .cnt_o(pc_neg));

  // With TRUNC_BITS = 0 the truncation is an identity, so the exact build shares this path
  assign pc_pos_t = PC_W'(trunc_pc(int'(pc_pos), TRUNC_BITS));
  assign pc_neg_t = PC_W'(trunc_pc(int'(pc_neg), TRUNC_BITS));

  assign beat_delta = SUM_W'(pc_pos_t) - SUM_W'(pc_neg_t);
  assign acc_sum    = acc_q + beat_delta;

  assign bus.in_ready = (state_q == ACC) ? 1'b1 : bus.out_ready;
  assign beat_acc     = bus.in_valid && bus.in_ready;
  assign last_beat    = (beat_q == LAST_BEAT);

  // acc_q and beat_q are already cleared in HOLD, so a beat taken there is beat 0 of the next frame
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_fire_d  = out_fire_q;

    if (state_q == HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACC;
    end

    if (beat_acc) begin
      if (last_beat) begin
        out_sum_d   = acc_sum;
        out_fire_d  = (acc_sum >= THRESH_S);
        out_valid_d = 1'b1;
        acc_d       = '0;
        beat_d      = '0;
        state_d     = HOLD;
      end else begin
        acc_d  = acc_sum;
        beat_d = beat_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_fire_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_fire_q  <= out_fire_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_fire  = out_fire_q;
endmodule

// File: tb/tb_ternary_popcount_acc.sv
// Directed bench for ternary_popcount_acc with default parameters; expectations follow TERNARY_POPCOUNT_APPROX_EN.
module tb_ternary_popcount_acc;
  localparam int IN_W  = 23;
  localparam int SUM_W = 8;

`ifdef TERNARY_POPCOUNT_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  localparam logic [IN_W-1:0] ONES = {IN_W{1'b1}};

  typedef struct {
    logic [IN_W-1:0] pos;
    logic [IN_W-1:0] neg;
    int              sum_exact;
    bit              fire_exact;
    int              sum_approx;
    bit              fire_approx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ternary_popcount_acc_if #(.IN_W(IN_W), .SUM_W(SUM_W)) bus ();

  ternary_popcount_acc #(
    .IN_W(IN_W), .BEATS(4), .THRESH(0), .TRUNC(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [IN_W-1:0] pos, input logic [IN_W-1:0] neg,
                           input int exp_sum, input bit exp_fire, input string tag);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pos   = pos;
      bus.in_neg   = neg;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_sum"},   int'(bus.out_sum),   exp_sum);
    check({tag, "_fire"},  int'(bus.out_fire),  int'(exp_fire));
  endtask

  vec_t vecs[9];
  int   f_sum[3];
  int   one_bit_sum;

  initial begin
    vecs[0] = '{ONES,          '0,            92, 1'b1,  88, 1'b1};
    vecs[1] = '{'0,            ONES,         -92, 1'b0, -88, 1'b0};
    vecs[2] = '{23'h000001,    23'h000001,     0, 1'b1,   0, 1'b1};
    vecs[3] = '{23'h000001,    '0,             4, 1'b1,   0, 1'b1};
    vecs[4] = '{23'h000007,    23'h000008,     8, 1'b1,   8, 1'b1};
    vecs[5] = '{23'h000003,    23'h000004,     4, 1'b1,   8, 1'b1};
    vecs[6] = '{23'h000001,    23'h00000E,    -8, 1'b0,  -8, 1'b0};
    vecs[7] = '{'0,            23'h000001,    -4, 1'b0,   0, 1'b1};
    vecs[8] = '{ONES,          23'h000001,    88, 1'b1,  88, 1'b1};
    one_bit_sum = APPROX ? 0 : 4;

    bus.in_valid  = 1'b0;
    bus.in_pos    = '0;
    bus.in_neg    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_sum",   int'(bus.out_sum),   0);
    check("rst_fire",  int'(bus.out_fire),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Table of single frames
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].pos, vecs[i].neg,
                APPROX ? vecs[i].sum_approx : vecs[i].sum_exact,
                APPROX ? vecs[i].fire_approx : vecs[i].fire_exact,
                $sformatf("vec%0d", i));
    end

    // Backpressure: result held, incoming beat stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    run_frame(ONES, '0, APPROX ? 88 : 92, 1'b1, "bp_frame");
    bus.in_valid = 1'b1;
    bus.in_pos   = 23'h000001;
    bus.in_neg   = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_in_ready_c%0d", c), int'(bus.in_ready), 0);
      check($sformatf("bp_valid_c%0d", c),    int'(bus.out_valid), 1);
      check($sformatf("bp_sum_c%0d", c),      int'(bus.out_sum), APPROX ? 88 : 92);
      check($sformatf("bp_fire_c%0d", c),     int'(bus.out_fire), 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    check("bp_release_valid_drop", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_valid", int'(bus.out_valid), 1);
    check("bp_next_sum",   int'(bus.out_sum),   one_bit_sum);

    // Back-to-back: 12 beats, results every 4 cycles with no gap
    f_sum[0] = one_bit_sum;
    f_sum[1] = APPROX ? 88 : 92;
    f_sum[2] = APPROX ? -88 : -92;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c > 0 && (c % 4) == 0) begin
        check($sformatf("b2b_valid_c%0d", c), int'(bus.out_valid), 1);
        check($sformatf("b2b_sum_c%0d", c),   int'(bus.out_sum), f_sum[c/4 - 1]);
      end else begin
        check($sformatf("b2b_idle_c%0d", c), int'(bus.out_valid), 0);
      end
      if (c < 12) begin
        bus.in_valid = 1'b1;
        bus.in_pos   = (c / 4 == 0) ? 23'h000001 : ((c / 4 == 1) ? ONES : '0);
        bus.in_neg   = (c / 4 == 2) ? ONES : '0;
        #1;
        check($sformatf("b2b_in_ready_c%0d", c), int'(bus.in_ready), 1);
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a frame
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pos   = ONES;
      bus.in_neg   = '0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_sum",   int'(bus.out_sum),   0);
    check("mid_rst_fire",  int'(bus.out_fire),  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    run_frame(23'h000001, '0, one_bit_sum, 1'b1, "post_rst");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
